// File: rtl/apb_master_arb.sv
// Two-requester round-robin arbiter driving one APB master port.
// IDLE/SETUP/ACCESS sequencing with wait states, timeout and late read capture.
module apb_master_arb #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16,
  parameter int RD_LATE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_valid,
  input  logic              r0_write,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_done,
  output logic              r0_err,
  input  logic              r1_valid,
  input  logic              r1_write,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_done,
  output logic              r1_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              psel,
  output logic              pen,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RDWAIT
  } state_t;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] WAIT_LAST =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t state, state_nx;

  logic [CW-1:0] wait_cnt;
  logic          last_gnt;
  logic          gnt;
  logic          done_q;
  logic          err_q;
  logic          take;
  logic          finish;
  logic          abort;
  logic          rd_cap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // The done cycle is itself an IDLE cycle that must not arbitrate,
  // so a requester that just completed cannot be granted again.
  always_comb begin
    state_nx = state;
    take     = 1'b0;
    finish   = 1'b0;
    abort    = 1'b0;
    rd_cap   = 1'b0;
    if (r0_valid && r1_valid) gnt = ~last_gnt;
    else                      gnt = r1_valid;
    unique case (state)
      IDLE: begin
        if (!done_q && (r0_valid || r1_valid)) begin
          take     = 1'b1;
          state_nx = SETUP;
        end
      end
      SETUP: state_nx = ACCESS;
      ACCESS: begin
        if (pready) begin
          if (!pwrite && RD_LATE != 0) begin
            state_nx = RDWAIT;
          end else begin
            finish   = 1'b1;
            rd_cap   = !pwrite;
            state_nx = IDLE;
          end
        end else if (TIMEOUT > 0 && wait_cnt == WAIT_LAST) begin
          abort    = 1'b1;
          state_nx = IDLE;
        end
      end
      RDWAIT: begin
        finish   = 1'b1;
        rd_cap   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_gnt  <= 1'b1;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rsp_rdata <= '0;
      wait_cnt  <= '0;
    end else begin
      done_q <= finish | abort;
      err_q  <= abort;
      if (take) begin
        last_gnt <= gnt;
        pwrite   <= gnt ? r1_write : r0_write;
        paddr    <= gnt ? r1_addr  : r0_addr;
        pwdata   <= gnt ? r1_wdata : r0_wdata;
      end
      if (abort)       rsp_rdata <= '0;
      else if (rd_cap) rsp_rdata <= prdata;
      if (state == ACCESS && !pready) wait_cnt <= wait_cnt + 1'b1;
      else                            wait_cnt <= '0;
    end
  end

  assign psel    = (state == SETUP) || (state == ACCESS);
  assign pen     = (state == ACCESS);
  assign busy    = (state != IDLE);
  assign r0_done = done_q & ~last_gnt;
  assign r1_done = done_q &  last_gnt;
  assign r0_err  = err_q  & ~last_gnt;
  assign r1_err  = err_q  &  last_gnt;

endmodule

// File: tb/tb_apb_master_arb.sv
// Bench for apb_master_arb: memory slave on a late-read instance,
// compliant slave on an early-read instance, scoreboard of responses.
module tb_apb_master_arb;

  typedef struct {
    int          idx;
    logic        err;
    logic        chk_rd;
    logic [31:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  valid = '0;
  logic [1:0]  wr = '0;
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic        r0_done, r1_done, r0_err, r1_err;
  logic [31:0] rsp_rdata;
  logic        busy, psel, pen, pwrite, pready;
  logic [31:0] paddr, pwdata;
  logic [31:0] prdata = '0;

  logic        b_valid = 1'b0;
  logic        b_write = 1'b0;
  logic [31:0] b_addr = '0;
  logic [31:0] b_wdata = '0;
  logic        b_done, b_err, b_r1_done, b_r1_err;
  logic [31:0] b_rdata;
  logic        b_busy, b_psel, b_pen, b_pwrite, b_pready;
  logic [31:0] b_paddr, b_pwdata, b_prdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t sbq [$];

  logic [31:0] mem [16];
  int          acc = 0;
  int          wait_n = 0;
  logic        hang = 1'b0;

  logic [1:0]  h_ph [256];
  logic [31:0] h_addr [256];
  logic [31:0] h_wd [256];

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    h_ph[cyc & 255]   <= {psel, pen};
    h_addr[cyc & 255] <= paddr;
    h_wd[cyc & 255]   <= pwdata;
  end

  initial begin
    addr[0] = '0; addr[1] = '0;
    wdata[0] = '0; wdata[1] = '0;
  end

  apb_master_arb #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT(16), .RD_LATE(1)
  ) u_dut (
    .clk(clk), .reset(reset),
    .r0_valid(valid[0]), .r0_write(wr[0]),
    .r0_addr(addr[0]), .r0_wdata(wdata[0]),
    .r0_done(r0_done), .r0_err(r0_err),
    .r1_valid(valid[1]), .r1_write(wr[1]),
    .r1_addr(addr[1]), .r1_wdata(wdata[1]),
    .r1_done(r1_done), .r1_err(r1_err),
    .rsp_rdata(rsp_rdata), .busy(busy),
    .psel(psel), .pen(pen), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .prdata(prdata)
  );

  apb_master_arb #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT(16), .RD_LATE(0)
  ) u_early (
    .clk(clk), .reset(reset),
    .r0_valid(b_valid), .r0_write(b_write),
    .r0_addr(b_addr), .r0_wdata(b_wdata),
    .r0_done(b_done), .r0_err(b_err),
    .r1_valid(1'b0), .r1_write(1'b0),
    .r1_addr(32'h0), .r1_wdata(32'h0),
    .r1_done(b_r1_done), .r1_err(b_r1_err),
    .rsp_rdata(b_rdata), .busy(b_busy),
    .psel(b_psel), .pen(b_pen), .pwrite(b_pwrite),
    .paddr(b_paddr), .pwdata(b_pwdata),
    .pready(b_pready), .prdata(b_prdata)
  );

  // Memory slave that registers prdata on the completing edge.
  assign pready = psel && pen && !hang && (acc >= wait_n);

  always @(posedge clk) begin
    if (reset) begin
      acc <= 0;
    end else if (psel && pen) begin
      if (pready) begin
        acc <= 0;
        if (pwrite) mem[paddr[3:0]] <= pwdata;
        else        prdata <= mem[paddr[3:0]];
      end else begin
        acc <= acc + 1;
      end
    end
  end

  assign b_pready = b_psel && b_pen;
  assign b_prdata = b_pready ? 32'hCAFEF00D : 32'h0;

  task automatic sb_monitor();
    exp_t e;
    int   gi;
    logic ge;
    forever begin
      @(negedge clk);
      if (r0_done || r1_done) begin
        gi = r1_done ? 1 : 0;
        ge = r1_done ? r1_err : r0_err;
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL sb_extra: done from r%0d, none expected", gi);
        end else begin
          e = sbq.pop_front();
          if (gi !== e.idx || ge !== e.err ||
              (e.chk_rd && rsp_rdata !== e.rdata)) begin
            errors++;
            $display("FAIL sb_rsp: got r%0d err=%b rdata=%h, want r%0d err=%b rdata=%h",
                     gi, ge, rsp_rdata, e.idx, e.err, e.rdata);
          end
        end
      end
    end
  endtask

  task automatic do_req(input int i, input logic w,
                        input logic [31:0] a, input logic [31:0] d,
                        output int t0, output int tdone);
    @(posedge clk);
    #1;
    valid[i] = 1'b1;
    wr[i]    = w;
    addr[i]  = a;
    wdata[i] = d;
    t0       = cyc;
    tdone    = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if ((i == 0 && r0_done) || (i == 1 && r1_done)) begin
        tdone    = cyc;
        valid[i] = 1'b0;
        break;
      end
    end
    if (tdone < 0) begin
      checks++;
      errors++;
      valid[i] = 1'b0;
      $display("FAIL req_wait: r%0d no done within 60 cycles", i);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({psel, pen, pwrite, busy, r0_done, r1_done, r0_err, r1_err} !== 8'h0) begin
      errors++;
      $display("FAIL reset_ctl: got %b, want 00000000",
               {psel, pen, pwrite, busy, r0_done, r1_done, r0_err, r1_err});
    end
    checks++;
    if (paddr !== 32'h0 || pwdata !== 32'h0 || rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: paddr=%h pwdata=%h rdata=%h, want 0",
               paddr, pwdata, rsp_rdata);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({psel, pen, busy, r0_done, r1_done} !== 5'h0) begin
      errors++;
      $display("FAIL reset_idle: got %b, want 00000",
               {psel, pen, busy, r0_done, r1_done});
    end
    checks++;
    if ({b_psel, b_pen, b_busy, b_done} !== 4'h0 || b_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_early: ctl=%b rdata=%h, want 0",
               {b_psel, b_pen, b_busy, b_done}, b_rdata);
    end
  endtask

  task automatic test_rr();
    int t, d0, d1, lat;
    for (int p = 0; p < 2; p++) begin
      sbq.push_back('{idx: 0, err: 1'b0, chk_rd: (p == 1), rdata: 32'h11});
      sbq.push_back('{idx: 1, err: 1'b0, chk_rd: (p == 1), rdata: 32'h22});
      @(posedge clk);
      #1;
      valid    = 2'b11;
      wr       = (p == 0) ? 2'b11 : 2'b00;
      addr[0]  = 32'd1;
      addr[1]  = 32'd2;
      wdata[0] = 32'h11;
      wdata[1] = 32'h22;
      t  = cyc;
      d0 = -1;
      d1 = -1;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (r0_done) begin d0 = cyc; valid[0] = 1'b0; end
        if (r1_done) begin d1 = cyc; valid[1] = 1'b0; end
        if (valid == 2'b00) break;
      end
      valid = 2'b00;
      lat = (p == 0) ? 3 : 4;
      checks++;
      if (d0 !== t + lat) begin
        errors++;
        $display("FAIL rr_first%0d: r0 done at %0d, want %0d", p, d0, t + lat);
      end
      checks++;
      if (d1 !== d0 + lat + 1) begin
        errors++;
        $display("FAIL rr_second%0d: r1 done at %0d, want %0d",
                 p, d1, d0 + lat + 1);
      end
    end
  endtask

  task automatic test_write_read();
    int t, d;
    sbq.push_back('{idx: 0, err: 1'b0, chk_rd: 1'b0, rdata: 32'h0});
    do_req(0, 1'b1, 32'd5, 32'hDEADBEEF, t, d);
    checks++;
    if (d !== t + 3) begin
      errors++;
      $display("FAIL wr_lat: done at %0d, want %0d", d, t + 3);
    end
    checks++;
    if (h_ph[(t + 1) & 255] !== 2'b10 || h_ph[(t + 2) & 255] !== 2'b11) begin
      errors++;
      $display("FAIL wr_phase: setup=%b access=%b, want 10 11",
               h_ph[(t + 1) & 255], h_ph[(t + 2) & 255]);
    end
    checks++;
    if (h_addr[(t + 1) & 255] !== 32'd5 || h_wd[(t + 2) & 255] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wr_bus: paddr=%h pwdata=%h, want 5 deadbeef",
               h_addr[(t + 1) & 255], h_wd[(t + 2) & 255]);
    end
    sbq.push_back('{idx: 0, err: 1'b0, chk_rd: 1'b1, rdata: 32'hDEADBEEF});
    do_req(0, 1'b0, 32'd5, 32'h0, t, d);
    checks++;
    if (d !== t + 4) begin
      errors++;
      $display("FAIL rd_lat: done at %0d, want %0d", d, t + 4);
    end
    checks++;
    if (h_ph[(t + 3) & 255] !== 2'b00) begin
      errors++;
      $display("FAIL rd_rdwait: psel/pen=%b, want 00", h_ph[(t + 3) & 255]);
    end
  endtask

  task automatic test_wait();
    int t, d;
    logic ok;
    wait_n = 3;
    sbq.push_back('{idx: 0, err: 1'b0, chk_rd: 1'b0, rdata: 32'h0});
    do_req(0, 1'b1, 32'd7, 32'h12345678, t, d);
    wait_n = 0;
    checks++;
    if (d !== t + 6) begin
      errors++;
      $display("FAIL wait_lat: done at %0d, want %0d", d, t + 6);
    end
    ok = 1'b1;
    for (int c = t + 2; c <= t + 5; c++) begin
      if (h_ph[c & 255] !== 2'b11 || h_addr[c & 255] !== 32'd7 ||
          h_wd[c & 255] !== 32'h12345678) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_stable: bus not held over 4 access cycles, got ok=%b want 1", ok);
    end
  endtask

  task automatic test_timeout();
    int t, d, n;
    hang = 1'b1;
    sbq.push_back('{idx: 0, err: 1'b1, chk_rd: 1'b1, rdata: 32'h0});
    do_req(0, 1'b0, 32'd9, 32'h0, t, d);
    hang = 1'b0;
    checks++;
    if (d !== t + 18) begin
      errors++;
      $display("FAIL to_lat: done at %0d, want %0d", d, t + 18);
    end
    checks++;
    if (psel !== 1'b0 || pen !== 1'b0) begin
      errors++;
      $display("FAIL to_release: psel=%b pen=%b, want 0 0", psel, pen);
    end
    n = 0;
    for (int c = t + 2; c < d; c++) if (h_ph[c & 255] === 2'b11) n++;
    checks++;
    if (n !== 16) begin
      errors++;
      $display("FAIL to_count: %0d access cycles, want 16", n);
    end
  endtask

  task automatic test_reset_mid();
    int t, d, nd;
    logic seen;
    wait_n = 8;
    sbq.push_back('{idx: 1, err: 1'b0, chk_rd: 1'b0, rdata: 32'h0});
    @(posedge clk);
    #1;
    valid[1] = 1'b1;
    wr[1]    = 1'b1;
    addr[1]  = 32'd3;
    wdata[1] = 32'h33;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (pen) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL rm_access: pen=%b, want 1", pen);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({psel, pen, busy} !== 3'b000) begin
      errors++;
      $display("FAIL rm_async: psel/pen/busy=%b, want 000", {psel, pen, busy});
    end
    nd = 0;
    repeat (3) begin
      @(negedge clk);
      if (r0_done || r1_done) nd++;
    end
    wait_n = 0;
    @(posedge clk);
    #1 reset = 1'b0;
    t = cyc;
    d = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (r0_done || r1_done) nd++;
      if (r1_done) begin d = cyc; valid[1] = 1'b0; break; end
    end
    valid[1] = 1'b0;
    checks++;
    if (nd !== 1) begin
      errors++;
      $display("FAIL rm_dones: %0d done pulses, want 1", nd);
    end
    checks++;
    if (d !== t + 3) begin
      errors++;
      $display("FAIL rm_lat: done at %0d, want %0d", d, t + 3);
    end
  endtask

  task automatic test_rd_early();
    int t, d;
    logic [31:0] rd;
    logic er;
    @(posedge clk);
    #1;
    b_valid = 1'b1;
    b_write = 1'b0;
    b_addr  = 32'd4;
    t  = cyc;
    d  = -1;
    rd = '0;
    er = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (b_done) begin
        d  = cyc;
        rd = b_rdata;
        er = b_err;
        b_valid = 1'b0;
        break;
      end
    end
    b_valid = 1'b0;
    checks++;
    if (d !== t + 3) begin
      errors++;
      $display("FAIL early_lat: done at %0d, want %0d", d, t + 3);
    end
    checks++;
    if (rd !== 32'hCAFEF00D || er !== 1'b0) begin
      errors++;
      $display("FAIL early_data: rdata=%h err=%b, want cafef00d 0", rd, er);
    end
  endtask

  initial begin
    fork
      sb_monitor();
    join_none
    test_reset();
    test_rr();
    test_write_read();
    test_wait();
    test_timeout();
    test_reset_mid();
    test_rd_early();
    repeat (3) @(negedge clk);
    checks++;
    if (sbq.size() !== 0) begin
      errors++;
      $display("FAIL sb_left: %0d responses outstanding, want 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
